// File: rtl/stopwatch_counter.sv
// MM:SS BCD stopwatch core with pause button debouncer and per-digit adjust mode.
// Optional macro STOPWATCH_BTN_SYNC_EN adds a 2-flop synchronizer on pause_btn.
module stopwatch_counter #(
   parameter int DEBOUNCE_CYCLES = 16,
   parameter int DB_W            = 5
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       one_hz_en,
   input  logic       two_hz_en,
   input  logic       pause_btn,
   input  logic       adj,
   input  logic [1:0] sel,
   output logic [3:0] sec0,
   output logic [2:0] sec1,
   output logic [3:0] min0,
   output logic [2:0] min1,
   output logic       paused
);

   typedef enum logic [1:0] {
      RUN    = 2'd0,
      PAUSED = 2'd1,
      ADJUST = 2'd2
   } state_t;

   state_t            state;
   state_t            state_n;
   logic              pause_flag;
   logic              flag_n;
   logic              count_en;
   logic              step_en;
   logic              btn_in;
   logic              db_level;
   logic              db_prev;
   logic [DB_W-1:0]   db_cnt;
   logic              press;

`ifdef STOPWATCH_BTN_SYNC_EN
   logic [1:0] btn_sync;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         btn_sync <= 2'b00;
      end else begin
         btn_sync <= {btn_sync[0], pause_btn};
      end
   end

   assign btn_in = btn_sync[1];
`else
   assign btn_in = pause_btn;
`endif

   // The debounced level only flips once the new level has held for the full window.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         db_cnt   <= '0;
         db_level <= 1'b0;
         db_prev  <= 1'b0;
      end else begin
         db_prev <= db_level;
         if (btn_in != db_level) begin
            if (db_cnt == DB_W'(DEBOUNCE_CYCLES - 1)) begin
               db_level <= btn_in;
               db_cnt   <= '0;
            end else begin
               db_cnt <= db_cnt + DB_W'(1);
            end
         end else begin
            db_cnt <= '0;
         end
      end
   end

   assign press = db_level & ~db_prev;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= RUN;
         pause_flag <= 1'b0;
      end else begin
         state      <= state_n;
         pause_flag <= flag_n;
      end
   end

   // pause_flag is always 0 in RUN and 1 in PAUSED, so it doubles as the paused output.
   always_comb begin
      state_n  = state;
      flag_n   = pause_flag;
      count_en = 1'b0;
      step_en  = 1'b0;
      case (state)
         RUN: begin
            count_en = one_hz_en;
            if (adj) begin
               state_n = ADJUST;
            end else if (press) begin
               flag_n  = 1'b1;
               state_n = PAUSED;
            end
         end
         PAUSED: begin
            if (adj) begin
               state_n = ADJUST;
            end else if (press) begin
               flag_n  = 1'b0;
               state_n = RUN;
            end
         end
         ADJUST: begin
            step_en = two_hz_en;
            if (press) begin
               flag_n = ~pause_flag;
            end
            if (!adj) begin
               state_n = flag_n ? PAUSED : RUN;
            end
         end
         default: begin
            state_n = RUN;
            flag_n  = 1'b0;
         end
      endcase
   end

   assign paused = pause_flag;

   // Counting ripples carries across digits; adjust steps a single digit with no carry.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sec0 <= 4'd0;
         sec1 <= 3'd0;
         min0 <= 4'd0;
         min1 <= 3'd0;
      end else if (count_en) begin
         if (sec0 == 4'd9) begin
            sec0 <= 4'd0;
            if (sec1 == 3'd5) begin
               sec1 <= 3'd0;
               if (min0 == 4'd9) begin
                  min0 <= 4'd0;
                  min1 <= (min1 == 3'd5) ? 3'd0 : min1 + 3'd1;
               end else begin
                  min0 <= min0 + 4'd1;
               end
            end else begin
               sec1 <= sec1 + 3'd1;
            end
         end else begin
            sec0 <= sec0 + 4'd1;
         end
      end else if (step_en) begin
         case (sel)
            2'b00:   sec0 <= (sec0 == 4'd9) ? 4'd0 : sec0 + 4'd1;
            2'b01:   sec1 <= (sec1 == 3'd5) ? 3'd0 : sec1 + 3'd1;
            2'b10:   min0 <= (min0 == 4'd9) ? 4'd0 : min0 + 4'd1;
            default: min1 <= (min1 == 3'd5) ? 3'd0 : min1 + 3'd1;
         endcase
      end
   end

endmodule

// File: tb/tb_stopwatch_counter.sv
// Self-checking bench for stopwatch_counter: directed scenarios plus random traffic,
// compared against a model that keeps time as a plain seconds count.
module tb_stopwatch_counter;

   localparam int DEB      = 16;
   localparam int M_RUN    = 0;
   localparam int M_PAUSED = 1;
   localparam int M_ADJ    = 2;

   logic       clk = 1'b0;
   logic       rst;
   logic       one_hz_en;
   logic       two_hz_en;
   logic       pause_btn;
   logic       adj;
   logic [1:0] sel;
   logic [3:0] sec0;
   logic [2:0] sec1;
   logic [3:0] min0;
   logic [2:0] min1;
   logic       paused;

   int checks = 0;
   int errors = 0;

   int m_secs;
   int m_mode;
   bit m_flag;
   bit m_deb;
   bit m_deb_prev;
   int m_run;
   bit m_s1;
   bit m_s2;
   bit btn_lvl;
   bit adj_lvl;

   always #5 clk = ~clk;

   stopwatch_counter #(
      .DEBOUNCE_CYCLES(DEB),
      .DB_W(5)
   ) dut (
      .clk(clk),
      .rst(rst),
      .one_hz_en(one_hz_en),
      .two_hz_en(two_hz_en),
      .pause_btn(pause_btn),
      .adj(adj),
      .sel(sel),
      .sec0(sec0),
      .sec1(sec1),
      .min0(min0),
      .min1(min1),
      .paused(paused)
   );

   function automatic logic [15:0] toBcd(input int s);
      logic [15:0] r;
      r = {1'b0, 3'(s / 600), 4'((s / 60) % 10), 1'b0, 3'((s / 10) % 6), 4'(s % 10)};
      return r;
   endfunction

   function automatic int digitOf(input int s, input int w);
      int d[4];
      d[0] = s % 10;
      d[1] = (s / 10) % 6;
      d[2] = (s / 60) % 10;
      d[3] = s / 600;
      return d[w];
   endfunction

   function automatic int bumpDigit(input int s, input logic [1:0] which);
      int d[4];
      d[0] = s % 10;
      d[1] = (s / 10) % 6;
      d[2] = (s / 60) % 10;
      d[3] = s / 600;
      d[which] = (d[which] + 1) % (which[0] ? 6 : 10);
      return d[3] * 600 + d[2] * 60 + d[1] * 10 + d[0];
   endfunction

   task automatic modelReset();
      m_secs     = 0;
      m_mode     = M_RUN;
      m_flag     = 1'b0;
      m_deb      = 1'b0;
      m_deb_prev = 1'b0;
      m_run      = 0;
      m_s1       = 1'b0;
      m_s2       = 1'b0;
   endtask

   // One clock edge of the reference model, using the inputs the DUT just sampled.
   task automatic modelStep();
      bit press;
      bit btn_eff;
      press = m_deb && !m_deb_prev;
`ifdef STOPWATCH_BTN_SYNC_EN
      btn_eff = m_s2;
      m_s2    = m_s1;
      m_s1    = pause_btn;
`else
      btn_eff = pause_btn;
`endif
      m_deb_prev = m_deb;
      if (btn_eff != m_deb) begin
         m_run++;
         if (m_run == DEB) begin
            m_deb = btn_eff;
            m_run = 0;
         end
      end else begin
         m_run = 0;
      end
      case (m_mode)
         M_RUN: begin
            if (one_hz_en) m_secs = (m_secs + 1) % 3600;
            if (adj) m_mode = M_ADJ;
            else if (press) begin
               m_flag = 1'b1;
               m_mode = M_PAUSED;
            end
         end
         M_PAUSED: begin
            if (adj) m_mode = M_ADJ;
            else if (press) begin
               m_flag = 1'b0;
               m_mode = M_RUN;
            end
         end
         default: begin
            if (two_hz_en) m_secs = bumpDigit(m_secs, sel);
            if (press) m_flag = !m_flag;
            if (!adj) m_mode = m_flag ? M_PAUSED : M_RUN;
         end
      endcase
   endtask

   task automatic applyStimulus(input bit btn, input bit a, input logic [1:0] s,
                                input bit one, input bit two);
      pause_btn = btn;
      adj       = a;
      sel       = s;
      one_hz_en = one;
      two_hz_en = two;
      @(posedge clk);
      modelStep();
      #1;
   endtask

   task automatic checkOutput(input string tag);
      logic [15:0] obs;
      logic [15:0] exp_t;
      bit          exp_p;
      obs   = {1'b0, min1, min0, 1'b0, sec1, sec0};
      exp_t = toBcd(m_secs);
      exp_p = (m_mode == M_PAUSED) || (m_mode == M_ADJ && m_flag);
      checks++;
      assert ({obs, paused} === {exp_t, exp_p}) else begin
         errors++;
         $error("[TB] FAIL %s: observed time %h paused %b, expected time %h paused %b",
                tag, obs, paused, exp_t, exp_p);
      end
   endtask

   task automatic checkConst(input string tag, input logic [15:0] exp_t, input bit exp_p);
      logic [15:0] obs;
      obs = {1'b0, min1, min0, 1'b0, sec1, sec0};
      checks++;
      assert ({obs, paused} === {exp_t, exp_p}) else begin
         errors++;
         $error("[TB] FAIL %s: observed time %h paused %b, expected time %h paused %b",
                tag, obs, paused, exp_t, exp_p);
      end
   endtask

   task automatic checkPaused(input string tag, input bit exp_p);
      checks++;
      assert (paused === exp_p) else begin
         errors++;
         $error("[TB] FAIL %s: observed paused %b, expected paused %b", tag, paused, exp_p);
      end
   endtask

   task automatic cycle(input bit btn, input bit a, input logic [1:0] s,
                        input bit one, input bit two, input string tag);
      applyStimulus(btn, a, s, one, two);
      checkOutput(tag);
   endtask

   task automatic adjustTo(input int target);
      int guard;
      for (int w = 3; w >= 0; w--) begin
         guard = 0;
         while (digitOf(m_secs, w) != digitOf(target, w) && guard < 12) begin
            cycle(btn_lvl, 1'b1, 2'(w), 1'($urandom_range(0, 1)), 1'b1, "adjust_step");
            guard++;
         end
      end
   endtask

   task automatic holdButton(input bit lvl, input int n, input bit a, input string tag);
      btn_lvl = lvl;
      for (int i = 0; i < n; i++) begin
         cycle(lvl, a, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'b0, tag);
      end
   endtask

   initial begin
      bit hit;
      bit pr;
      rst       = 1'b1;
      pause_btn = 1'b0;
      adj       = 1'b0;
      sel       = 2'b00;
      one_hz_en = 1'b0;
      two_hz_en = 1'b0;
      btn_lvl   = 1'b0;
      modelReset();
      @(posedge clk);
      #1;
      checkConst("reset_hold", 16'h0000, 1'b0);
      rst = 1'b0;

      // Sixty ticks with irregular gaps; two_hz_en and sel must not matter in RUN.
      for (int i = 0; i < 60; i++) begin
         repeat ($urandom_range(0, 2))
            cycle(1'b0, 1'b0, 2'($urandom_range(0, 3)), 1'b0, 1'($urandom_range(0, 1)), "run_idle");
         cycle(1'b0, 1'b0, 2'($urandom_range(0, 3)), 1'b1, 1'($urandom_range(0, 1)), "run_tick");
      end
      checkConst("sixty_ticks", 16'h0100, 1'b0);

      cycle(1'b0, 1'b1, 2'b00, 1'b0, 1'b0, "adj_enter");
      adjustTo(3599);
      checkConst("preload_5959", 16'h5959, 1'b0);
      cycle(1'b0, 1'b0, 2'b00, 1'b0, 1'b0, "adj_exit");
      cycle(1'b0, 1'b0, 2'b00, 1'b1, 1'b0, "wrap_tick");
      checkConst("wrap_to_zero", 16'h0000, 1'b0);

      cycle(1'b0, 1'b1, 2'b00, 1'b0, 1'b0, "adj_enter");
      adjustTo(40);
      cycle(1'b0, 1'b1, 2'b01, 1'b1, 1'b1, "sec1_step");
      checkConst("sec1_to_5", 16'h0050, 1'b0);
      cycle(1'b0, 1'b1, 2'b01, 1'b1, 1'b1, "sec1_step");
      checkConst("sec1_wrap", 16'h0000, 1'b0);
      cycle(1'b0, 1'b1, 2'b01, 1'b1, 1'b1, "sec1_step");
      checkConst("sec1_to_1", 16'h0010, 1'b0);
      cycle(1'b0, 1'b1, 2'b00, 1'b1, 1'b0, "sel_change");
      checkConst("sel_change_no_step", 16'h0010, 1'b0);
      cycle(1'b0, 1'b1, 2'b00, 1'b0, 1'b1, "sec0_step");
      checkConst("sec0_step", 16'h0011, 1'b0);
      cycle(1'b0, 1'b0, 2'b00, 1'b0, 1'b0, "adj_exit");

      // A glitch one cycle short of the window must not pause.
      holdButton(1'b1, DEB - 1, 1'b0, "glitch_high");
      holdButton(1'b0, DEB + 4, 1'b0, "glitch_low");
      checkPaused("glitch_ignored", 1'b0);
      holdButton(1'b1, DEB + 6, 1'b0, "press1");
      checkPaused("press_pauses", 1'b1);
      holdButton(1'b0, DEB + 4, 1'b0, "release1");
      checkPaused("still_paused", 1'b1);
      holdButton(1'b1, DEB + 6, 1'b0, "press2");
      checkPaused("press_resumes", 1'b0);
      holdButton(1'b0, DEB + 4, 1'b0, "release2");

      // Tick aligned exactly with the accepted press at 00:09.
      cycle(1'b0, 1'b1, 2'b00, 1'b0, 1'b0, "adj_enter");
      adjustTo(9);
      cycle(1'b0, 1'b0, 2'b00, 1'b0, 1'b0, "adj_exit");
      hit     = 1'b0;
      btn_lvl = 1'b1;
      for (int i = 0; i < DEB + 8 && !hit; i++) begin
         pr = m_deb && !m_deb_prev;
         cycle(1'b1, 1'b0, 2'b00, pr, 1'b0, "press_tick");
         if (pr) hit = 1'b1;
      end
      checkConst("tick_and_press", 16'h0010, 1'b1);
      btn_lvl = 1'b0;
      for (int i = 0; i < DEB + 4; i++) cycle(1'b0, 1'b0, 2'b00, 1'b0, 1'b0, "release3");
      btn_lvl = 1'b1;
      for (int i = 0; i < DEB + 6; i++) cycle(1'b1, 1'b0, 2'b00, 1'b0, 1'b0, "press4");
      btn_lvl = 1'b0;
      for (int i = 0; i < DEB + 4; i++) cycle(1'b0, 1'b0, 2'b00, 1'b0, 1'b0, "release4");
      checkConst("resumed", 16'h0010, 1'b0);

      // A press inside ADJUST only toggles the stored flag, which decides the exit state.
      cycle(1'b0, 1'b1, 2'b00, 1'b0, 1'b0, "adj_enter");
      btn_lvl = 1'b1;
      for (int i = 0; i < DEB + 6; i++) cycle(1'b1, 1'b1, 2'b00, 1'b1, 1'b0, "adj_press");
      btn_lvl = 1'b0;
      for (int i = 0; i < DEB + 4; i++) cycle(1'b0, 1'b1, 2'b00, 1'b1, 1'b0, "adj_release");
      cycle(1'b0, 1'b0, 2'b00, 1'b0, 1'b0, "adj_exit");
      checkConst("adjust_press_exit", 16'h0010, 1'b1);

      cycle(1'b0, 1'b1, 2'b00, 1'b0, 1'b0, "adj_enter");
      adjustTo(754);
      cycle(1'b0, 1'b0, 2'b00, 1'b0, 1'b0, "adj_exit");
      checkConst("at_1234", 16'h1234, 1'b1);
      #2;
      rst = 1'b1;
      #1;
      checkConst("async_reset", 16'h0000, 1'b0);
      modelReset();
      @(posedge clk);
      #1;
      rst = 1'b0;

      // Random traffic: slow button, occasional adjust toggles, frequent ticks.
      btn_lvl = 1'b0;
      adj_lvl = 1'b0;
      for (int i = 0; i < 1500; i++) begin
         if ($urandom_range(0, 24) == 0) btn_lvl = !btn_lvl;
         if ($urandom_range(0, 59) == 0) adj_lvl = !adj_lvl;
         cycle(btn_lvl, adj_lvl, 2'($urandom_range(0, 3)),
               1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 2) == 0), "random");
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #1000000;
      $display("[TB] FAIL watchdog: observed timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
